pc_sequencer: RTL and testbench

//  Owns the program counter. Sits directly downstream of the instruction decoder/FSM.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_target_calc.sv | 51 +++++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Branch offset in bytes: sign-extended word offset shifted left by two.
  function automatic logic [31:0] sext16_shl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder <-> PC sequencer bundle: strobes and fields in, PC state out.
interface pc_sequencer_if;
  logic        stall;
  logic        J_Signal;
  logic        JAL_Signal;
  logic        JR_Signal;
  logic        BEQ_Signal;
  logic        BNE_Signal;
  logic        zero;
  logic [25:0] instr_index;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        redirect;
  logic        misalign_err;

  modport master (
    output stall, J_Signal, JAL_Signal, JR_Signal, BEQ_Signal, BNE_Signal,
    output zero, instr_index, imm16, rs_data,
    input  pc, pc_plus4, link_addr, redirect, misalign_err
  );

  modport slave (
    input  stall, J_Signal, JAL_Signal, JR_Signal, BEQ_Signal, BNE_Signal,
    input  zero, instr_index, imm16, rs_data,
    output pc, pc_plus4, link_addr, redirect, misalign_err
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational control-flow resolver: decides taken/target for the current
// instruction with priority JR > JAL > J > BEQ > BNE.
module pc_target_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  input  logic        j_strobe,
  input  logic        jal_strobe,
  input  logic        jr_strobe,
  input  logic        beq_strobe,
  input  logic        bne_strobe,
  input  logic        zero,
  output logic        taken,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;

  assign branch_target_s = pc_plus4 + sext16_shl2(imm16);
  assign jump_target_s   = {pc_plus4[31:28], instr_index, 2'b00};

  // Priority resolution of the decoder strobes.
  always_comb begin
    taken    = 1'b0;
    target   = 32'h0000_0000;
    misalign = 1'b0;
    if (jr_strobe) begin
      taken    = 1'b1;
      target   = {rs_data[31:2], 2'b00};
      misalign = (rs_data[1:0] != 2'b00);
    end else if (jal_strobe || j_strobe) begin
      taken  = 1'b1;
      target = jump_target_s;
    end else if (beq_strobe) begin
      taken  = zero;
      target = branch_target_s;
    end else if (bne_strobe) begin
      taken  = ~zero;
      target = branch_target_s;
    end else begin
      taken  = 1'b0;
      target = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register, redirect flag and sticky jr-misalign flag.
// Build option: DELAY_SLOT_EN enables the MIPS branch delay slot (SEQ/SLOT FSM).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  logic [31:0] pc_r;
  logic        redirect_r;
  logic        misalign_err_r;
  logic [31:0] pc_plus4_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic        misalign_s;

  assign pc_plus4_s = pc_r + 32'd4;

  pc_target_calc u_target_calc (
    .pc_plus4    (pc_plus4_s),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .rs_data     (bus.rs_data),
    .j_strobe    (bus.J_Signal),
    .jal_strobe  (bus.JAL_Signal),
    .jr_strobe   (bus.JR_Signal),
    .beq_strobe  (bus.BEQ_Signal),
    .bne_strobe  (bus.BNE_Signal),
    .zero        (bus.zero),
    .taken       (taken_s),
    .target      (target_s),
    .misalign    (misalign_s)
  );

`ifdef DELAY_SLOT_EN
  pc_state_e   state_r;
  logic [31:0] target_r;

  // Delay-slot FSM: a taken transfer first executes pc+4, then jumps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r           <= RESET_PC;
      redirect_r     <= 1'b0;
      misalign_err_r <= 1'b0;
      state_r        <= SEQ;
      target_r       <= 32'h0000_0000;
    end else if (!bus.stall) begin
      case (state_r)
        SEQ: begin
          pc_r           <= pc_plus4_s;
          redirect_r     <= 1'b0;
          misalign_err_r <= misalign_err_r | misalign_s;
          if (taken_s) begin
            target_r <= target_s;
            state_r  <= SLOT;
          end else begin
            state_r  <= SEQ;
          end
        end
        SLOT: begin
          // Slot instruction's own strobes are deliberately ignored.
          pc_r       <= target_r;
          redirect_r <= 1'b1;
          state_r    <= SEQ;
        end
        default: begin
          pc_r       <= RESET_PC;
          redirect_r <= 1'b0;
          state_r    <= SEQ;
        end
      endcase
    end else begin
      pc_r <= pc_r;
    end
  end

  assign bus.link_addr = pc_r + 32'd8;
`else
  // Immediate redirect: taken transfers load the target on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r           <= RESET_PC;
      redirect_r     <= 1'b0;
      misalign_err_r <= 1'b0;
    end else if (!bus.stall) begin
      misalign_err_r <= misalign_err_r | misalign_s;
      if (taken_s) begin
        pc_r       <= target_s;
        redirect_r <= 1'b1;
      end else begin
        pc_r       <= pc_plus4_s;
        redirect_r <= 1'b0;
      end
    end else begin
      pc_r <= pc_r;
    end
  end

  assign bus.link_addr = pc_plus4_s;
`endif

  assign bus.pc           = pc_r;
  assign bus.pc_plus4     = pc_plus4_s;
  assign bus.redirect     = redirect_r;
  assign bus.misalign_err = misalign_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against an architectural PC model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_pc;
  logic        m_red;
  logic        m_err;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_valid = 1'b0;

`ifdef DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFS = 32'd8;
`else
  localparam logic [31:0] LINK_OFS = 32'd4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 1'b0;
    bus.J_Signal = 1'b0; bus.JAL_Signal = 1'b0; bus.JR_Signal = 1'b0;
    bus.BEQ_Signal = 1'b0; bus.BNE_Signal = 1'b0;
    bus.zero = 1'b0; bus.instr_index = 26'h0; bus.imm16 = 16'h0; bus.rs_data = 32'h0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic tick();
    logic [31:0] p4, tg;
    logic        tk, mis;
    int          off;
    #1;
    p4 = m_pc + 32'd4;
    if (m_valid) begin
      chk("pc_plus4", bus.pc_plus4, p4);
      chk("link_addr", bus.link_addr, m_pc + LINK_OFS);
    end
    tk = 1'b0; mis = 1'b0; tg = 32'h0;
    if (bus.JR_Signal) begin
      tk = 1'b1; tg = bus.rs_data & ~32'd3; mis = (bus.rs_data % 32'd4) != 32'd0;
    end else if (bus.JAL_Signal || bus.J_Signal) begin
      tk = 1'b1; tg = (p4 & 32'hF000_0000) | (32'(bus.instr_index) << 2);
    end else if (bus.BEQ_Signal || bus.BNE_Signal) begin
      tk  = bus.BEQ_Signal ? bus.zero : !bus.zero;
      off = int'($signed(bus.imm16));
      tg  = p4 + 32'(off * 4);
    end
    @(posedge clk);
    if (reset) begin
      m_pc = 32'h0; m_red = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_tgt = 32'h0;
      m_valid = 1'b1;
    end else if (!bus.stall) begin
`ifdef DELAY_SLOT_EN
      if (m_pend) begin
        m_pc = m_tgt; m_red = 1'b1; m_pend = 1'b0;
      end else begin
        m_pc = p4; m_red = 1'b0; m_err = m_err | mis;
        if (tk) begin m_pend = 1'b1; m_tgt = tg; end
      end
`else
      m_pc  = tk ? tg : p4;
      m_red = tk;
      m_err = m_err | mis;
`endif
    end
    #1;
    if (m_valid) begin
      chk("pc", bus.pc, m_pc);
      chk("redirect", {31'h0, bus.redirect}, {31'h0, m_red});
      chk("misalign_err", {31'h0, bus.misalign_err}, {31'h0, m_err});
    end
  endtask

  // Aligned JR to reach an arbitrary PC (plus slot cycle when enabled).
  task automatic jump_to(input logic [31:0] addr);
    idle(); bus.JR_Signal = 1'b1; bus.rs_data = addr; tick(); idle();
`ifdef DELAY_SLOT_EN
    tick();
`endif
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_redirect", {31'h0, bus.redirect}, 32'h0);
    chk("reset_err", {31'h0, bus.misalign_err}, 32'h0);
    reset = 1'b0;
    tick(); chk("idle_pc4", bus.pc, 32'h4);
    tick(); chk("idle_pc8", bus.pc, 32'h8);
    tick(); chk("idle_pcC", bus.pc, 32'hC);

    // BEQ taken, backward offset
    jump_to(32'h100);
    bus.BEQ_Signal = 1'b1; bus.zero = 1'b1; bus.imm16 = 16'hFFFE; tick(); idle();
`ifdef DELAY_SLOT_EN
    chk("beq_slot_pc", bus.pc, 32'h104);
    tick();
`endif
    chk("beq_taken_pc", bus.pc, 32'hFC);
    chk("beq_taken_red", {31'h0, bus.redirect}, 32'h1);
    tick();
    chk("beq_red_drop", {31'h0, bus.redirect}, 32'h0);

    // BEQ not taken
    jump_to(32'h100);
    bus.BEQ_Signal = 1'b1; bus.zero = 1'b0; bus.imm16 = 16'hFFFE; tick(); idle();
    chk("beq_nt_pc", bus.pc, 32'h104);
    chk("beq_nt_red", {31'h0, bus.redirect}, 32'h0);

    // JAL and link address
    jump_to(32'h3000_0010);
    bus.JAL_Signal = 1'b1; bus.instr_index = 26'h40;
    #1;
`ifdef DELAY_SLOT_EN
    chk("jal_link", bus.link_addr, 32'h3000_0018);
`else
    chk("jal_link", bus.link_addr, 32'h3000_0014);
`endif
    tick(); idle();
`ifdef DELAY_SLOT_EN
    tick();
`endif
    chk("jal_pc", bus.pc, 32'h3000_0100);

    // Misaligned JR, sticky error
    bus.JR_Signal = 1'b1; bus.rs_data = 32'h203; tick(); idle();
`ifdef DELAY_SLOT_EN
    tick();
`endif
    chk("jr_pc", bus.pc, 32'h200);
    chk("jr_err", {31'h0, bus.misalign_err}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("jr_err_sticky", {31'h0, bus.misalign_err}, 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("jr_err_cleared", {31'h0, bus.misalign_err}, 32'h0);

    // Wrap-around and stall
    jump_to(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", bus.pc, 32'h0);
    bus.stall = 1'b1; bus.J_Signal = 1'b1; bus.instr_index = 26'h123;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc, 32'h0);
    end
    idle(); tick();
    chk("post_stall_pc", bus.pc, 32'h4);

`ifdef DELAY_SLOT_EN
    // Delay slot: branch in slot ignored, stall in slot holds, reset drops target
    jump_to(32'h40);
    bus.J_Signal = 1'b1; bus.instr_index = 26'h20; tick(); idle();
    chk("slot_pc", bus.pc, 32'h44);
    chk("slot_red", {31'h0, bus.redirect}, 32'h0);
    bus.stall = 1'b1; tick(); tick(); bus.stall = 1'b0;
    chk("slot_stall_pc", bus.pc, 32'h44);
    bus.BNE_Signal = 1'b1; bus.zero = 1'b0; bus.imm16 = 16'h0100; tick(); idle();
    chk("slot_target_pc", bus.pc, 32'h80);
    chk("slot_target_red", {31'h0, bus.redirect}, 32'h1);
    bus.J_Signal = 1'b1; bus.instr_index = 26'h20; tick(); idle();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("slot_reset_pc", bus.pc, 32'h0);
    tick();
    chk("slot_dropped_pc", bus.pc, 32'h4);
    chk("slot_dropped_red", {31'h0, bus.redirect}, 32'h0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      reset     = ($urandom_range(0, 49) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.zero  = $urandom_range(0, 1) == 1;
      bus.instr_index = 26'($urandom);
      bus.imm16       = 16'($urandom);
      bus.rs_data     = $urandom;
      if ($urandom_range(0, 3) != 0) bus.rs_data[1:0] = 2'b00;
      r = int'($urandom_range(0, 9));
      case (r)
        0: bus.J_Signal   = 1'b1;
        1: bus.JAL_Signal = 1'b1;
        2: bus.JR_Signal  = 1'b1;
        3: bus.BEQ_Signal = 1'b1;
        4: bus.BNE_Signal = 1'b1;
        5: begin
          bus.J_Signal   = $urandom_range(0, 1) == 1;
          bus.JAL_Signal = $urandom_range(0, 1) == 1;
          bus.JR_Signal  = $urandom_range(0, 1) == 1;
          bus.BEQ_Signal = $urandom_range(0, 1) == 1;
          bus.BNE_Signal = $urandom_range(0, 1) == 1;
        end
        default: ;
      endcase
      tick();
    end
    reset = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
